xor_diff_pipe: RTL
==================

// Module: xor_diff_pipe
// PURPOSE
//  Parametrised, pipelined successor to the 1-bit XOR gate: computes the WIDTH-bit
//  bitwise XOR of two operands, its reduction parity and an equality flag.
//  Two register stages with valid/ready flow control on both sides.
//  Used as the datapath compare/diff unit feeding flag logic and self-check hooks.
// PARAMETERS
//  WIDTH   64  operand and result width in bits (>= 1)
//  CNT_W   16  mismatch counter width (used only with MISMATCH_CNT_EN)
// PORTS
//  clk           in   1      single clock, all state updates on rising edge
//  reset         in   1      asynchronous, active-high reset
//  in_valid      in   1      upstream operands valid
//  in_ready      out  1      block can accept operands this cycle
//  in_a          in   WIDTH  operand A
//  in_b          in   WIDTH  operand B
//  out_valid     out  1      result valid
//  out_ready     in   1      downstream accepts result this cycle
//  out_xor       out  WIDTH  in_a ^ in_b
//  out_parity    out  1      ^(in_a ^ in_b): 1 = odd number of differing bits
//  out_equal     out  1      1 when in_a == in_b (out_xor all zero)
//  clr_cnt       in   1      sync clear of mismatch_cnt (MISMATCH_CNT_EN only)
//  mismatch_cnt  out  CNT_W  count of delivered unequal results (MISMATCH_CNT_EN only)
// BEHAVIOUR
//  - Reset (async, active-high): s1_valid, s2_valid, out_valid = 0; all data regs,
//    out_xor, out_parity, out_equal = 0; mismatch_cnt = 0. Held while reset = 1.
//  - Accept: input transfer when in_valid && in_ready. Output transfer when
//    out_valid && out_ready. Data on an un-transferred output holds stable.
//  - Stage 1 registers diff = in_a ^ in_b and s1_valid.
//  - Stage 2 registers out_xor = diff, out_parity = ^diff, out_equal = (diff == 0).
//  - s2 advance: adv2 = !s2_valid || out_ready. s1 advance: adv1 = !s1_valid || adv2.
//  - in_ready = adv1 (combinational from out_ready; no combinational in_valid->in_ready).
//  - Latency: 2 cycles accept-to-out_valid with out_ready held 1; throughput 1/cycle.
//  - Full: both stages valid and out_ready = 0 -> in_ready = 0, nothing moves, no loss.
//  - Bubble: when adv2 and s1 empty, s2_valid clears next cycle if its output transferred.
//  - Simultaneous accept and deliver on a full pipe: both occur, order preserved.
//  - Results delivered in strict acceptance order; no drop, no duplication.
//  - Reset asserted mid-operation: all in-flight results discarded, counter zeroed.
//  - WIDTH = 1 is legal: block reduces to registered XOR; out_parity == out_xor.
// CONFIGURATION
//  - MISMATCH_CNT_EN defined: clr_cnt and mismatch_cnt ports exist. Counter +1 on
//    each output transfer with out_equal = 0; saturates at all ones (no wrap);
//    clr_cnt = 1 forces 0 next edge and wins over a simultaneous increment.
//  - MISMATCH_CNT_EN undefined: clr_cnt/mismatch_cnt ports and counter logic absent;
//    datapath and handshake behaviour identical.
// TESTING
//  1. Reset: assert reset mid-stream with 2 results in flight -> out_valid = 0,
//     in_ready = 1, outputs 0 immediately; no stale result after release.
//  2. Streaming, WIDTH=64, out_ready=1: A=0xFFFF_0000_FFFF_0000, B=0x0F0F_0F0F_0F0F_0F0F
//     -> 2 cycles later out_xor=0xF0F0_0F0F_F0F0_0F0F, parity=0, equal=0; then
//     A=B=0x1234 -> equal=1, parity=0; A=1,B=0 -> parity=1.
//  3. Backpressure: out_ready=0, push 3 items -> 2 held, in_ready=0 on 3rd;
//     raise out_ready -> all 3 delivered in order, stable while stalled.
//  4. Simultaneous accept+deliver with pipe full for 10 cycles -> 1 result/cycle,
//     scoreboard matches, no gaps.
//  5. MISMATCH_CNT_EN, CNT_W=2: deliver 5 unequal results -> cnt saturates at 3;
//     clr_cnt with concurrent unequal delivery -> cnt = 0; equal results never count.
//  6. WIDTH=1 sweep of 00,01,10,11 -> out_xor 0,1,1,0, matches truth table of a 2-input XOR.

Source files
------------

// File: rtl/xor_diff_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : xor_diff_pipe_if
// Brief    : Handshake and data bundle for xor_diff_pipe. Operands travel
//            upstream to downstream, and results travel back with valid/ready.
//            The optional mismatch counter signals exist only when
//            MISMATCH_CNT_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
interface xor_diff_pipe_if #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_xor;
  logic             out_parity;
  logic             out_equal;

`ifdef MISMATCH_CNT_EN
  logic             clr_cnt;
  logic [CNT_W-1:0] mismatch_cnt;

  // The master is the environment around the block: it drives operands and
  // accepts results.
  modport master (
    output in_valid, in_a, in_b, out_ready, clr_cnt,
    input  in_ready, out_valid, out_xor, out_parity, out_equal, mismatch_cnt
  );
  // The slave is the compare/diff unit itself.
  modport slave (
    input  in_valid, in_a, in_b, out_ready, clr_cnt,
    output in_ready, out_valid, out_xor, out_parity, out_equal, mismatch_cnt
  );
`else
  // CNT_W only sizes the counter. It is kept here so that both builds
  // instantiate the interface with the same parameter list.
  if (CNT_W < 1) begin : g_cnt_w_unused
  end

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_xor, out_parity, out_equal
  );
  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_xor, out_parity, out_equal
  );
`endif
endinterface
`default_nettype wire

// File: rtl/xor_diff_pipe.sv
`default_nettype none
// ============================================================================
// Module   : xor_diff_pipe
// Brief    : Two-stage pipelined WIDTH-bit XOR with reduction parity and
//            equality flag, using valid/ready flow control on both sides.
//            Define MISMATCH_CNT_EN to add a saturating count of delivered
//            unequal results, with a synchronous clear.
// Revision : 1.0  initial release
// ============================================================================
module xor_diff_pipe #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic           clk,
  input  logic           reset,
  xor_diff_pipe_if.slave bus
);

  logic             adv1;
  logic             adv2;
  logic             s1_valid_d, s1_valid_q;
  logic [WIDTH-1:0] s1_diff_d,  s1_diff_q;
  logic             s2_valid_d, s2_valid_q;
  logic [WIDTH-1:0] out_xor_d,  out_xor_q;
  logic             out_parity_d, out_parity_q;
  logic             out_equal_d,  out_equal_q;

  // A stage may advance when it is empty or when the stage after it is
  // moving. Ready therefore depends only on state and out_ready.
  always_comb begin
    adv2 = !s2_valid_q || bus.out_ready;
    adv1 = !s1_valid_q || adv2;
  end

  assign bus.in_ready   = adv1;
  assign bus.out_valid  = s2_valid_q;
  assign bus.out_xor    = out_xor_q;
  assign bus.out_parity = out_parity_q;
  assign bus.out_equal  = out_equal_q;

  // Stage 1 captures the raw difference vector when an operand pair is
  // accepted. Data holds otherwise, which avoids needless toggling.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_diff_d  = s1_diff_q;
    if (adv1) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_diff_d = bus.in_a ^ bus.in_b;
      end
    end
  end

  // Stage 2 derives the flags from the stage-1 diff. Output data changes only
  // when a new result moves in, so it stays stable while the output is stalled.
  always_comb begin
    s2_valid_d   = s2_valid_q;
    out_xor_d    = out_xor_q;
    out_parity_d = out_parity_q;
    out_equal_d  = out_equal_q;
    if (adv2) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_xor_d    = s1_diff_q;
        out_parity_d = ^s1_diff_q;
        out_equal_d  = (s1_diff_q == '0);
      end
    end
  end

  // Pipeline registers. Reset discards everything in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s1_diff_q    <= '0;
      s2_valid_q   <= 1'b0;
      out_xor_q    <= '0;
      out_parity_q <= 1'b0;
      out_equal_q  <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_diff_q    <= s1_diff_d;
      s2_valid_q   <= s2_valid_d;
      out_xor_q    <= out_xor_d;
      out_parity_q <= out_parity_d;
      out_equal_q  <= out_equal_d;
    end
  end

`ifdef MISMATCH_CNT_EN
  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  logic [CNT_W-1:0] mismatch_cnt_d, mismatch_cnt_q;

  assign bus.mismatch_cnt = mismatch_cnt_q;

  // Count unequal results at the moment they are handed downstream. The
  // counter saturates instead of wrapping, and clear wins over a concurrent
  // increment.
  always_comb begin
    mismatch_cnt_d = mismatch_cnt_q;
    if (bus.clr_cnt) begin
      mismatch_cnt_d = '0;
    end else if (s2_valid_q && bus.out_ready && !out_equal_q &&
                 (mismatch_cnt_q != C_CNT_MAX)) begin
      mismatch_cnt_d = mismatch_cnt_q + CNT_W'(1);
    end
  end

  // Mismatch counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mismatch_cnt_q <= '0;
    end else begin
      mismatch_cnt_q <= mismatch_cnt_d;
    end
  end
`else
  // CNT_W only sizes the optional counter. It is retained so that both builds
  // share one parameter list.
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

endmodule
`default_nettype wire
